// File: rtl/alu_pkg.sv
// Shared encodings for the execute-stage ALU: op codes, forward selects, mul/div FSM states.
package alu_pkg;

    localparam logic [4:0] OpAdd   = 5'h00;
    localparam logic [4:0] OpSub   = 5'h01;
    localparam logic [4:0] OpAnd   = 5'h02;
    localparam logic [4:0] OpOr    = 5'h03;
    localparam logic [4:0] OpXor   = 5'h04;
    localparam logic [4:0] OpNor   = 5'h05;
    localparam logic [4:0] OpSltu  = 5'h06;
    localparam logic [4:0] OpSll   = 5'h07;
    localparam logic [4:0] OpSrl   = 5'h08;
    localparam logic [4:0] OpSlt   = 5'h09;
    localparam logic [4:0] OpSra   = 5'h0A;
    localparam logic [4:0] OpLui   = 5'h0B;
    localparam logic [4:0] OpMfhi  = 5'h0C;
    localparam logic [4:0] OpMflo  = 5'h0D;
    localparam logic [4:0] OpMthi  = 5'h0E;
    localparam logic [4:0] OpMtlo  = 5'h0F;
    localparam logic [4:0] OpMult  = 5'h10;
    localparam logic [4:0] OpMultu = 5'h11;
    localparam logic [4:0] OpDiv   = 5'h12;
    localparam logic [4:0] OpDivu  = 5'h13;

    localparam logic [1:0] FwdReg    = 2'b00;
    localparam logic [1:0] FwdResW   = 2'b01;
    localparam logic [1:0] FwdAluM   = 2'b10;
    localparam logic [1:0] FwdRegAlt = 2'b11;

    typedef enum logic [1:0] {StIdle, StRun, StDone} md_state_e;

endpackage

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide unit with HI/LO registers and stall request.
// FAST_MUL_EN: MULT/MULTU become single-cycle and bypass the FSM.
module muldiv_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       op,
    input  logic             flush,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy
);

    localparam int unsigned CntW = $clog2(WIDTH);

    md_state_e          state_q, state_d;
    logic [CntW-1:0]    cnt_q;
    logic [WIDTH-1:0]   opb_q;
    logic [2*WIDTH-1:0] part_q;
    logic               is_div_q, sign_a_q, sign_b_q;
    logic [WIDTH-1:0]   hi_q, lo_q;

    logic               iter_op, fast_op, is_signed, is_div, accept, run_step;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     mul_sum, div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic [2*WIDTH-1:0] mul_next, div_next, step, mul_res;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

`ifdef FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_prod;
    assign iter_op   = (op == OpDiv) || (op == OpDivu);
    assign fast_op   = (op == OpMult) || (op == OpMultu);
    // Sign-extend to 2*WIDTH so the truncated product is correct for both signednesses.
    assign fast_prod = {{WIDTH{is_signed & src_a[WIDTH-1]}}, src_a}
                     * {{WIDTH{is_signed & src_b[WIDTH-1]}}, src_b};
`else
    assign iter_op   = (op == OpMult) || (op == OpMultu) || (op == OpDiv) || (op == OpDivu);
    assign fast_op   = 1'b0;
`endif

    assign is_signed = (op == OpMult) || (op == OpDiv);
    assign is_div    = (op == OpDiv) || (op == OpDivu);
    assign accept    = (state_q == StIdle) && iter_op && !flush;
    assign run_step  = (state_q == StRun) && !flush;

    assign a_neg = is_signed & src_a[WIDTH-1];
    assign b_neg = is_signed & src_b[WIDTH-1];
    assign a_abs = a_neg ? -src_a : src_a;
    assign b_abs = b_neg ? -src_b : src_b;

    // Shift-add: upper half accumulates, lower half holds the remaining multiplier bits.
    assign mul_sum  = {1'b0, part_q[2*WIDTH-1:WIDTH]} + (part_q[0] ? {1'b0, opb_q} : '0);
    assign mul_next = {mul_sum, part_q[WIDTH-1:1]};

    // Restoring divide: upper half is remainder, lower half shifts dividend out / quotient in.
    // The extra diff bit keeps divide-by-zero from looking like a borrow.
    assign div_shift = part_q[2*WIDTH-1:WIDTH-1];
    assign div_diff  = {1'b0, div_shift} - {2'b00, opb_q};
    assign div_next  = div_diff[WIDTH+1] ? {div_shift[WIDTH-1:0], part_q[WIDTH-2:0], 1'b0}
                                         : {div_diff[WIDTH-1:0], part_q[WIDTH-2:0], 1'b1};

    assign step    = is_div_q ? div_next : mul_next;
    assign mul_res = (sign_a_q ^ sign_b_q) ? -step : step;
    assign quo_fix = (sign_a_q ^ sign_b_q) ? -step[WIDTH-1:0] : step[WIDTH-1:0];
    assign rem_fix = sign_a_q ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept) state_d = StRun;
            StRun: begin
                if (flush)             state_d = StIdle;
                else if (cnt_q == '0)  state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = !rst && (accept || (state_q == StRun));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            opb_q    <= '0;
            part_q   <= '0;
            is_div_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else if (accept) begin
            cnt_q    <= CntW'(WIDTH - 1);
            opb_q    <= b_abs;
            part_q   <= {{WIDTH{1'b0}}, a_abs};
            is_div_q <= is_div;
            sign_a_q <= a_neg;
            sign_b_q <= is_div ? b_neg : b_neg;
        end else if (run_step) begin
            part_q <= step;
            cnt_q  <= cnt_q - 1'b1;
            if (cnt_q == '0) begin
                if (is_div_q) begin
                    hi_q <= rem_fix;
                    lo_q <= quo_fix;
                end else begin
                    {hi_q, lo_q} <= mul_res;
                end
            end
        end else if ((state_q == StIdle) && !flush) begin
            if (op == OpMthi) hi_q <= src_a;
            if (op == OpMtlo) lo_q <= src_a;
`ifdef FAST_MUL_EN
            if (fast_op) {hi_q, lo_q} <= fast_prod;
`endif
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: rtl/alu_muldiv_ex.sv
// Execute stage: forwarding muxes, single-cycle ALU and the iterative mul/div unit.
// Optional macro FAST_MUL_EN selects a single-cycle multiplier inside muldiv_seq.
module alu_muldiv_ex
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] RD1E,
    input  logic [WIDTH-1:0] RD2E,
    input  logic [WIDTH-1:0] ResultW,
    input  logic [WIDTH-1:0] ALUOutM,
    input  logic [WIDTH-1:0] SignImmE,
    input  logic [1:0]       ForwardAE,
    input  logic [1:0]       ForwardBE,
    input  logic             ALUSrcE,
    input  logic [4:0]       ALUCtrE,
    input  logic             FlushE,
    output logic [WIDTH-1:0] ALUOutE,
    output logic [WIDTH-1:0] WriteDataE,
    output logic             BusyE
);

    logic [WIDTH-1:0]   src_a, src_b, hi, lo;
    logic [SHAMT_W-1:0] shamt;

    always_comb begin
        case (ForwardAE)
            FwdResW: src_a = ResultW;
            FwdAluM: src_a = ALUOutM;
            default: src_a = RD1E;
        endcase
        case (ForwardBE)
            FwdResW: WriteDataE = ResultW;
            FwdAluM: WriteDataE = ALUOutM;
            default: WriteDataE = RD2E;
        endcase
    end

    assign src_b = ALUSrcE ? SignImmE : WriteDataE;
    assign shamt = src_b[SHAMT_W-1:0];

    always_comb begin
        ALUOutE = '0;
        case (ALUCtrE)
            OpAdd:   ALUOutE = src_a + src_b;
            OpSub:   ALUOutE = src_a - src_b;
            OpAnd:   ALUOutE = src_a & src_b;
            OpOr:    ALUOutE = src_a | src_b;
            OpXor:   ALUOutE = src_a ^ src_b;
            OpNor:   ALUOutE = ~(src_a | src_b);
            OpSltu:  ALUOutE = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
            OpSll:   ALUOutE = src_a << shamt;
            OpSrl:   ALUOutE = src_a >> shamt;
            OpSlt:   ALUOutE = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            OpSra:   ALUOutE = WIDTH'($signed(src_a) >>> shamt);
            OpLui:   ALUOutE = src_b << (WIDTH / 2);
            OpMfhi:  ALUOutE = hi;
            OpMflo:  ALUOutE = lo;
            default: ALUOutE = '0;
        endcase
    end

    muldiv_seq #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk  (clk),
        .rst  (rst),
        .op   (ALUCtrE),
        .flush(FlushE),
        .src_a(src_a),
        .src_b(src_b),
        .hi   (hi),
        .lo   (lo),
        .busy (BusyE)
    );

endmodule

// File: tb/tb_alu_muldiv_ex.sv
// Scoreboard bench for alu_muldiv_ex at WIDTH=32.
module tb_alu_muldiv_ex;
    import alu_pkg::*;

    logic        clk, rst;
    logic [31:0] RD1E, RD2E, ResultW, ALUOutM, SignImmE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        ALUSrcE, FlushE;
    logic [4:0]  ALUCtrE;
    logic [31:0] ALUOutE, WriteDataE;
    logic        BusyE;

    logic [31:0] sb_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

`ifdef FAST_MUL_EN
    localparam int MulBusy = 0;
`else
    localparam int MulBusy = 33;
`endif

    alu_muldiv_ex #(
        .WIDTH  (32),
        .SHAMT_W(5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .RD1E      (RD1E),
        .RD2E      (RD2E),
        .ResultW   (ResultW),
        .ALUOutM   (ALUOutM),
        .SignImmE  (SignImmE),
        .ForwardAE (ForwardAE),
        .ForwardBE (ForwardBE),
        .ALUSrcE   (ALUSrcE),
        .ALUCtrE   (ALUCtrE),
        .FlushE    (FlushE),
        .ALUOutE   (ALUOutE),
        .WriteDataE(WriteDataE),
        .BusyE     (BusyE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    task automatic issue(input string tag, input logic [4:0] op, input logic [1:0] fa,
                         input logic [1:0] fb, input logic src, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm, input logic [31:0] exp);
        @(posedge clk); #1;
        RD1E = a; RD2E = b; SignImmE = imm;
        ForwardAE = fa; ForwardBE = fb; ALUSrcE = src;
        ALUCtrE = op; FlushE = 1'b0;
        sb_q.push_back(exp);
        @(negedge clk);
        check(tag, ALUOutE, sb_q.pop_front());
    endtask

    task automatic alu(input string tag, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
        issue(tag, op, FwdReg, FwdReg, 1'b0, a, b, 32'h0, exp);
    endtask

    task automatic muldiv(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input int exp_busy);
        int          n;
        bit          done;
        logic [31:0] eh, el;
        @(posedge clk); #1;
        RD1E = a; RD2E = b; ForwardAE = FwdReg; ForwardBE = FwdReg;
        ALUSrcE = 1'b0; ALUCtrE = op; FlushE = 1'b0;
        sb_q.push_back(exp_hi);
        sb_q.push_back(exp_lo);
        n = 0;
        done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (BusyE) n++;
            else done = 1;
        end
        check({tag, " busy cycles"}, 64'(n), 64'(exp_busy));
        eh = sb_q.pop_front();
        el = sb_q.pop_front();
        alu({tag, " hi"}, OpMfhi, 32'h0, 32'h0, eh);
        alu({tag, " lo"}, OpMflo, 32'h0, 32'h0, el);
    endtask

    initial begin
        rst = 1'b1;
        RD1E = '0; RD2E = '0; SignImmE = '0;
        ResultW = 32'h10; ALUOutM = 32'h5;
        ForwardAE = FwdReg; ForwardBE = FwdReg;
        ALUSrcE = 1'b0; ALUCtrE = OpAdd; FlushE = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset busy", 64'(BusyE), 64'h0);
        rst = 1'b0;
        alu("reset hi", OpMfhi, 32'h0, 32'h0, 32'h0);
        alu("reset lo", OpMflo, 32'h0, 32'h0, 32'h0);

        // Forwarding and operand selection
        issue("fwd aluoutm", OpAdd, FwdAluM,   FwdReg, 1'b0, 32'h1, 32'h2, 32'h0, 32'h7);
        issue("fwd alt rd1", OpAdd, FwdRegAlt, FwdReg, 1'b0, 32'h1, 32'h2, 32'h0, 32'h3);
        issue("fwd resultw", OpAdd, FwdResW,   FwdReg, 1'b0, 32'h1, 32'h2, 32'h0, 32'h12);
        issue("imm src",     OpAdd, FwdReg,    FwdAluM, 1'b1, 32'h1, 32'h2, 32'h100, 32'h101);
        check("writedata fwd", 64'(WriteDataE), 64'h5);

        // Single-cycle ops
        alu("add wrap", OpAdd, 32'hFFFF_FFFF, 32'h1, 32'h0);
        alu("sub",      OpSub, 32'h3, 32'h5, 32'hFFFF_FFFE);
        alu("and",      OpAnd, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200);
        alu("or",       OpOr,  32'hF000_0001, 32'h0F00_0010, 32'hFF00_0011);
        alu("xor",      OpXor, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555);
        alu("nor",      OpNor, 32'hF000_000F, 32'h0F00_00F0, 32'h00FF_FF00);
        alu("slt",      OpSlt,  32'hFFFF_FFFF, 32'h1, 32'h1);
        alu("sltu",     OpSltu, 32'hFFFF_FFFF, 32'h1, 32'h0);
        alu("sll",      OpSll, 32'h1, 32'h1F, 32'h8000_0000);
        alu("sll shamt mask", OpSll, 32'h3, 32'h21, 32'h6);
        alu("srl",      OpSrl, 32'h8000_0000, 32'h4, 32'h0800_0000);
        alu("sra",      OpSra, 32'h8000_0000, 32'h4, 32'hF800_0000);
        alu("lui",      OpLui, 32'h0, 32'h1234, 32'h1234_0000);
        alu("bad op",   5'h1F, 32'h1234, 32'h5678, 32'h0);

        // HI/LO moves
        alu("mthi out", OpMthi, 32'hCAFE_0001, 32'h0, 32'h0);
        alu("mtlo out", OpMtlo, 32'hBEEF_0002, 32'h0, 32'h0);
        alu("mfhi",     OpMfhi, 32'h0, 32'h0, 32'hCAFE_0001);
        alu("mflo",     OpMflo, 32'h0, 32'h0, 32'hBEEF_0002);

        // Multiply / divide
        muldiv("mult -3*5",  OpMult,  32'hFFFF_FFFD, 32'h5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, MulBusy);
        muldiv("multu max",  OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFE, 32'h0000_0001, MulBusy);
        muldiv("div -7/2",   OpDiv,   32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
        muldiv("divu 7/0",   OpDivu,  32'h7, 32'h0, 32'h7, 32'hFFFF_FFFF, 33);
        muldiv("div min/-1", OpDiv,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33);
        muldiv("divu 100/3", OpDivu,  32'd100, 32'd3, 32'd1, 32'd33, 33);

        // Flush in the middle of a divide
        alu("pre-flush mthi", OpMthi, 32'hAAAA, 32'h0, 32'h0);
        alu("pre-flush mtlo", OpMtlo, 32'h5555, 32'h0, 32'h0);
        @(posedge clk); #1;
        RD1E = 32'd100; RD2E = 32'd3; ALUCtrE = OpDivu; FlushE = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        FlushE = 1'b1;
        @(negedge clk);
        check("flush busy same cycle", 64'(BusyE), 64'h1);
        @(posedge clk); #1;
        FlushE = 1'b0;
        ALUCtrE = OpAdd;
        @(negedge clk);
        check("flush busy next", 64'(BusyE), 64'h0);
        alu("flush hi kept", OpMfhi, 32'h0, 32'h0, 32'hAAAA);
        alu("flush lo kept", OpMflo, 32'h0, 32'h0, 32'h5555);

        // Reset in the middle of a multiply
        @(posedge clk); #1;
        RD1E = 32'd5; RD2E = 32'd6; ALUCtrE = OpMultu;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst busy", 64'(BusyE), 64'h0);
        ALUCtrE = OpAdd;
        @(negedge clk);
        rst = 1'b0;
        alu("rst hi", OpMfhi, 32'h0, 32'h0, 32'h0);
        alu("rst lo", OpMflo, 32'h0, 32'h0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
